branch_target_predictor: RTL and testbench
==========================================

BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16, giving the PC and target width.
REQ-002 The block SHALL have parameter INDEX_BITS, default 8, giving 2^INDEX_BITS table entries; tag width is WORD_SIZE-INDEX_BITS.
REQ-003 The block SHALL have parameter GHR_BITS, default 8, giving the global history length; GHR_BITS <= INDEX_BITS.
REQ-004 The block SHALL have one clock and an asynchronous active-high reset: clk  in  1  clock; reset  in  1  asynchronous active-high reset.
REQ-005 pc  in  WORD_SIZE  fetch PC to predict.
REQ-006 pred_next_pc  out  WORD_SIZE  predicted next PC.
REQ-007 pred_taken  out  1  prediction selects the table target.
REQ-008 pred_hit  out  1  valid entry with matching tag.
REQ-009 init_busy  out  1  table clear in progress.
REQ-010 upd_valid  in  1  resolved-branch update strobe.
REQ-011 upd_pc  in  WORD_SIZE  PC of the resolved branch or jump.
REQ-012 upd_is_cond  in  1  1 = conditional branch (BNE/BEQ/BGZ/BLZ), 0 = unconditional jump.
REQ-013 upd_taken  in  1  resolved direction.
REQ-014 upd_target  in  WORD_SIZE  resolved taken target.
REQ-015 upd_mispredict  in  1  fetch prediction for upd_pc was wrong.
REQ-016 mispredict_cnt  out  16  saturating count of mispredicts.

Function
REQ-017 Each entry SHALL hold: valid (1), tag, target (WORD_SIZE), and a 2-bit counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
REQ-018 The lookup index SHALL be pc[INDEX_BITS-1:0] and the tag SHALL be pc[WORD_SIZE-1:INDEX_BITS].
REQ-019 Prediction SHALL be combinational: pred_hit = valid & tag match; pred_taken = pred_hit & counter[1] & !init_busy; pred_next_pc = pred_taken ? target : pc+1, wrapping modulo 2^WORD_SIZE.
REQ-020 An update SHALL take effect at the clk edge on which upd_valid=1 and init_busy=0; updates while init_busy=1 SHALL be dropped.
REQ-021 Update on a hit for a conditional branch: counter +1 if taken, saturating at 11; -1 if not taken, saturating at 00; target <= upd_target if taken.
REQ-022 Update on a miss for a conditional branch: if taken, allocate (valid=1, new tag, target=upd_target, counter=10); if not taken, leave the entry unchanged.
REQ-023 Update for a jump (upd_is_cond=0), hit or miss: allocate or overwrite with counter=11 and target=upd_target.
REQ-024 When lookup and update hit the same index in one cycle, the prediction SHALL use the pre-update entry (read-before-write).
REQ-025 The GHR SHALL shift left, inserting upd_taken, only on accepted conditional updates.
REQ-026 mispredict_cnt SHALL increment on each accepted update with upd_mispredict=1 and hold at 16'hFFFF.

Reset
REQ-027 Asserting reset SHALL immediately clear the GHR, mispredict_cnt and the clear pointer, and SHALL set init_busy=1 (state INIT).
REQ-028 In INIT the block SHALL clear valid and set counter=01 for one entry per cycle, index 0 upward; init_busy SHALL remain 1 for exactly 2^INDEX_BITS cycles after reset deassertion, then the state SHALL move to READY.
REQ-029 Reset asserted mid-INIT SHALL restart the clear from index 0.
REQ-030 READY SHALL return to INIT only through reset.

Configuration
REQ-031 With BP_GSHARE_EN defined, both lookup and update index SHALL be the PC index XOR {zero-extended GHR}; without it, the index SHALL be PC bits only and the GHR SHALL be absent, with the tag unchanged in both cases.

Structure
REQ-032 A shared package SHALL hold the counter-state constants (SNT, WNT, WT, ST), the INIT/READY state encoding and the branch opcode constants.
REQ-033 The saturating 2-bit counter update SHALL be one sub-module, sat_counter2, instantiated on the update path.

Verification
REQ-034 Release reset, count cycles -> init_busy=1 for exactly 256 cycles (INDEX_BITS=8); any pc -> pred_next_pc=pc+1.
REQ-035 Taken conditional update pc=0x0012, target=0x0040 -> lookup 0x0012 gives pred_hit=1, pred_taken=1, next=0x0040; then two not-taken updates -> pred_taken=0, next=0x0013.
REQ-036 Entry at 0x0012, then lookup 0x0112 -> pred_hit=0, next=0x0113; jump update 0x0112 to 0x0200 -> entry replaced, counter=11.
REQ-037 Lookup and update of 0x0012 in the same cycle -> pre-update prediction returned; the new value is seen the next cycle; pc=0xFFFF miss -> next=0x0000.
REQ-038 Reset pulse at cycle 100 of INIT -> init_busy stays 1 for 256 further cycles; 70000 mispredict updates -> mispredict_cnt=0xFFFF.
REQ-039 With BP_GSHARE_EN defined, same PC with GHR=00 vs FF -> distinct entries trained independently.

Source files
------------

// File: rtl/branch_target_predictor_pkg.sv
// Shared constants for the branch target predictor: 2-bit counter states,
// INIT/READY state encoding and the branch opcode set.
package branch_target_predictor_pkg;

    // 2-bit direction counter states
    localparam logic [1:0] SNT = 2'b00;  // strong not-taken
    localparam logic [1:0] WNT = 2'b01;  // weak not-taken
    localparam logic [1:0] WT  = 2'b10;  // weak taken
    localparam logic [1:0] ST  = 2'b11;  // strong taken

    // Controller states
    localparam logic [0:0] STATE_INIT  = 1'b0;
    localparam logic [0:0] STATE_READY = 1'b1;

    // Branch/jump opcodes seen by the resolve stage
    localparam logic [2:0] OP_BNE = 3'd1;
    localparam logic [2:0] OP_BEQ = 3'd2;
    localparam logic [2:0] OP_BGZ = 3'd3;
    localparam logic [2:0] OP_BLZ = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;

    // Conditional branches train the counter; everything else is a jump
    function automatic logic is_cond_op(input logic [2:0] op);
        return (op == OP_BNE) || (op == OP_BEQ) || (op == OP_BGZ) || (op == OP_BLZ);
    endfunction

endpackage

// File: rtl/branch_target_predictor_sat_counter2.sv
// Saturating 2-bit up/down counter used on the predictor update path.
module sat_counter2
    import branch_target_predictor_pkg::*;
(
    input  logic [1:0] ctr_in,
    input  logic       inc,
    output logic [1:0] ctr_out
);

    // Step toward ST when taken, toward SNT when not taken, holding at the ends
    always_comb begin
        // NOTE: default assignment first so every path drives ctr_out and no latch is inferred.
        ctr_out = ctr_in;
        if (inc) begin
            if (ctr_in != ST) ctr_out = ctr_in + 2'd1;
        end else begin
            if (ctr_in != SNT) ctr_out = ctr_in - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target predictor with 2-bit direction counters,
// a reset-time table clear sweep and a saturating mispredict counter.
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int INDEX_BITS = 8,
    parameter int GHR_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] pred_next_pc,
    output logic                 pred_taken,
    output logic                 pred_hit,
    output logic                 init_busy,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic                 upd_is_cond,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_mispredict,
    output logic [15:0]          mispredict_cnt
);

    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;
    localparam int ENTRIES  = 1 << INDEX_BITS;

    if (GHR_BITS < 1 || GHR_BITS > INDEX_BITS) begin : g_bad_ghr
        $error("GHR_BITS must be in 1..INDEX_BITS");
    end

    // Prediction table
    logic                 valid_q  [ENTRIES];
    logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
    logic [WORD_SIZE-1:0] target_q [ENTRIES];
    logic [1:0]           ctr_q    [ENTRIES];

    logic [0:0]            state_q, state_d;
    logic [INDEX_BITS-1:0] clr_ptr_q, clr_ptr_d;
    logic [15:0]           mispredict_cnt_q, mispredict_cnt_d;
    logic [INDEX_BITS-1:0] hist_mix;

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    assign hist_mix = INDEX_BITS'(ghr_q);
`else
    assign hist_mix = '0;
`endif

    assign init_busy      = (state_q == STATE_INIT);
    assign mispredict_cnt = mispredict_cnt_q;

    // Lookup path: reads the table as it stands before this cycle's update
    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    assign lk_idx       = pc[INDEX_BITS-1:0] ^ hist_mix;
    assign lk_tag       = pc[WORD_SIZE-1:INDEX_BITS];
    assign pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken   = pred_hit && ctr_q[lk_idx][1] && !init_busy;
    assign pred_next_pc = pred_taken ? target_q[lk_idx] : pc + WORD_SIZE'(1);

    // Update path
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0]   up_tag;
    logic                  up_hit;
    logic                  upd_accept;
    logic [1:0]            ctr_next;
    assign up_idx     = upd_pc[INDEX_BITS-1:0] ^ hist_mix;
    assign up_tag     = upd_pc[WORD_SIZE-1:INDEX_BITS];
    assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign upd_accept = upd_valid && !init_busy;

    sat_counter2 u_sat_counter2 (
        .ctr_in  (ctr_q[up_idx]),
        .inc     (upd_taken),
        .ctr_out (ctr_next)
    );

    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_idx;
    logic                  wr_valid;
    logic [TAG_BITS-1:0]   wr_tag;
    logic [WORD_SIZE-1:0]  wr_target;
    logic [1:0]            wr_ctr;

    // Select the single table write for this cycle: clear sweep or resolved branch
    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = up_idx;
        wr_valid  = 1'b1;
        wr_tag    = up_tag;
        wr_target = upd_target;
        wr_ctr    = ST;
        if (init_busy) begin
            wr_en    = 1'b1;
            wr_idx   = clr_ptr_q;
            wr_valid = 1'b0;
            wr_ctr   = WNT;
        end else if (upd_valid) begin
            if (!upd_is_cond) begin
                wr_en  = 1'b1;
                wr_ctr = ST;
            end else if (up_hit) begin
                wr_en  = 1'b1;
                wr_ctr = ctr_next;
                if (!upd_taken) wr_target = target_q[up_idx];
            end else if (upd_taken) begin
                wr_en  = 1'b1;
                wr_ctr = WT;
            end
        end
    end

    // Table storage write port
    // NOTE: the table has no reset; the INIT sweep clears it one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            valid_q[wr_idx]  <= wr_valid;
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
            ctr_q[wr_idx]    <= wr_ctr;
        end
    end

    // Next-state for controller, clear pointer, mispredict counter and history
    always_comb begin
        state_d          = state_q;
        clr_ptr_d        = clr_ptr_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (state_q == STATE_INIT) begin
            clr_ptr_d = clr_ptr_q + INDEX_BITS'(1);
            if (clr_ptr_q == '1) state_d = STATE_READY;
        end
        if (upd_accept && upd_mispredict && (mispredict_cnt_q != 16'hFFFF)) begin
            mispredict_cnt_d = mispredict_cnt_q + 16'd1;
        end
`ifdef BP_GSHARE_EN
        ghr_d = ghr_q;
        if (upd_accept && upd_is_cond) ghr_d = (ghr_q << 1) | GHR_BITS'(upd_taken);
`endif
    end

    // Control registers with asynchronous reset into INIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= STATE_INIT;
            clr_ptr_q        <= '0;
            mispredict_cnt_q <= '0;
`ifdef BP_GSHARE_EN
            ghr_q            <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q          <= state_d;
            clr_ptr_q        <= clr_ptr_d;
            mispredict_cnt_q <= mispredict_cnt_d;
`ifdef BP_GSHARE_EN
            ghr_q            <= ghr_d;
`endif
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed self-checking bench for branch_target_predictor (default parameters).
// Define BP_GSHARE_EN to run the gshare scenario instead of the PC-indexed ones.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic [15:0] pred_next_pc;
    logic        pred_taken;
    logic        pred_hit;
    logic        init_busy;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_is_cond;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_mispredict;
    logic [15:0] mispredict_cnt;

    int errors = 0;
    int checks = 0;

    branch_target_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .pred_next_pc   (pred_next_pc),
        .pred_taken     (pred_taken),
        .pred_hit       (pred_hit),
        .init_busy      (init_busy),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_is_cond    (upd_is_cond),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    // One accepted-update cycle: fields driven at negedge, strobe dropped after the edge
    task automatic upd(input logic [15:0] p, input logic cond, input logic tk,
                       input logic [15:0] tgt, input logic mis);
        @(negedge clk);
        upd_pc = p; upd_is_cond = cond; upd_taken = tk; upd_target = tgt;
        upd_mispredict = mis; upd_valid = 1'b1;
        @(posedge clk); #1;
        upd_valid = 1'b0; upd_mispredict = 1'b0;
    endtask

    task automatic set_pc(input logic [15:0] p);
        pc = p; #1;
    endtask

    // Count clock edges until init_busy falls (bounded)
    task automatic count_init(output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (init_busy && n < 2000);
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; #7;
        checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", init_busy); end
        checks++; if (mispredict_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h expected 0000", mispredict_cnt); end
        set_pc(16'h00FF);
        checks++; if ({pred_taken, pred_next_pc} !== {1'b0, 16'h0100}) begin errors++; $display("FAIL reset_next: got taken=%b next=%h expected 0 0100", pred_taken, pred_next_pc); end
        @(negedge clk); reset = 1'b0;
        count_init(n);
        checks++; if (n !== 256) begin errors++; $display("FAIL init_cycles: got %0d expected 256", n); end
        set_pc(16'h1234);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b0, 1'b0, 16'h1235}) begin errors++; $display("FAIL ready_next: got %b %b %h expected 0 0 1235", pred_hit, pred_taken, pred_next_pc); end
    endtask

    task automatic test_train();
        set_pc(16'h0012);
        upd(16'h0012, 1, 1, 16'h0040, 0);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b1, 1'b1, 16'h0040}) begin errors++; $display("FAIL train_alloc: got %b %b %h expected 1 1 0040", pred_hit, pred_taken, pred_next_pc); end
        upd(16'h0012, 1, 0, 16'h0999, 0);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b1, 1'b0, 16'h0013}) begin errors++; $display("FAIL train_wnt: got %b %b %h expected 1 0 0013", pred_hit, pred_taken, pred_next_pc); end
        upd(16'h0012, 1, 0, 16'h0999, 0);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b1, 1'b0, 16'h0013}) begin errors++; $display("FAIL train_snt: got %b %b %h expected 1 0 0013", pred_hit, pred_taken, pred_next_pc); end
        upd(16'h0012, 1, 0, 16'h0999, 0);
        upd(16'h0012, 1, 1, 16'h0040, 0);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b1, 1'b0, 16'h0013}) begin errors++; $display("FAIL train_sat_low: got %b %b %h expected 1 0 0013", pred_hit, pred_taken, pred_next_pc); end
        upd(16'h0012, 1, 1, 16'h0040, 0);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b1, 1'b1, 16'h0040}) begin errors++; $display("FAIL train_wt: got %b %b %h expected 1 1 0040", pred_hit, pred_taken, pred_next_pc); end
        upd(16'h0012, 1, 1, 16'h0050, 0);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b1, 1'b1, 16'h0050}) begin errors++; $display("FAIL train_retarget: got %b %b %h expected 1 1 0050", pred_hit, pred_taken, pred_next_pc); end
        upd(16'h0012, 1, 1, 16'h0050, 0);
        upd(16'h0012, 1, 1, 16'h0050, 0);
        upd(16'h0012, 1, 0, 16'h0999, 0);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b1, 1'b1, 16'h0050}) begin errors++; $display("FAIL train_sat_high: got %b %b %h expected 1 1 0050", pred_hit, pred_taken, pred_next_pc); end
    endtask

    task automatic test_miss_and_jump();
        set_pc(16'h0112);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b0, 1'b0, 16'h0113}) begin errors++; $display("FAIL alias_miss: got %b %b %h expected 0 0 0113", pred_hit, pred_taken, pred_next_pc); end
        upd(16'h0112, 1, 0, 16'h0999, 0);
        set_pc(16'h0012);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b1, 1'b1, 16'h0050}) begin errors++; $display("FAIL nt_miss_keep: got %b %b %h expected 1 1 0050", pred_hit, pred_taken, pred_next_pc); end
        upd(16'h0112, 0, 1, 16'h0200, 0);
        set_pc(16'h0112);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b1, 1'b1, 16'h0200}) begin errors++; $display("FAIL jump_alloc: got %b %b %h expected 1 1 0200", pred_hit, pred_taken, pred_next_pc); end
        set_pc(16'h0012);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b0, 1'b0, 16'h0013}) begin errors++; $display("FAIL jump_replaced: got %b %b %h expected 0 0 0013", pred_hit, pred_taken, pred_next_pc); end
        set_pc(16'h0112);
        upd(16'h0112, 1, 0, 16'h0999, 0);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b1, 1'b1, 16'h0200}) begin errors++; $display("FAIL jump_st: got %b %b %h expected 1 1 0200", pred_hit, pred_taken, pred_next_pc); end
        upd(16'h0112, 1, 0, 16'h0999, 0);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b1, 1'b0, 16'h0113}) begin errors++; $display("FAIL jump_wnt: got %b %b %h expected 1 0 0113", pred_hit, pred_taken, pred_next_pc); end
        set_pc(16'h0A05);
        upd(16'h0A05, 1, 1, 16'h0123, 0);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b1, 1'b1, 16'h0123}) begin errors++; $display("FAIL cond_alloc: got %b %b %h expected 1 1 0123", pred_hit, pred_taken, pred_next_pc); end
        upd(16'h0A05, 1, 0, 16'h0999, 0);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b1, 1'b0, 16'h0A06}) begin errors++; $display("FAIL cond_alloc_wt: got %b %b %h expected 1 0 0a06", pred_hit, pred_taken, pred_next_pc); end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        pc = 16'h0012;
        upd_pc = 16'h0012; upd_is_cond = 1'b0; upd_taken = 1'b1; upd_target = 16'h0300;
        upd_mispredict = 1'b0; upd_valid = 1'b1;
        #1;
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b0, 1'b0, 16'h0013}) begin errors++; $display("FAIL rbw_pre: got %b %b %h expected 0 0 0013", pred_hit, pred_taken, pred_next_pc); end
        @(posedge clk); #1;
        upd_valid = 1'b0;
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b1, 1'b1, 16'h0300}) begin errors++; $display("FAIL rbw_post: got %b %b %h expected 1 1 0300", pred_hit, pred_taken, pred_next_pc); end
        set_pc(16'hFFFF);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b0, 1'b0, 16'h0000}) begin errors++; $display("FAIL pc_wrap: got %b %b %h expected 0 0 0000", pred_hit, pred_taken, pred_next_pc); end
    endtask

    task automatic test_reset_mid_init();
        int n;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL mid_init_busy: got %b expected 1", init_busy); end
        reset = 1'b1; #2; reset = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            if (n == 200) begin
                upd_pc = 16'h0012; upd_is_cond = 1'b0; upd_taken = 1'b1;
                upd_target = 16'h0777; upd_mispredict = 1'b1; upd_valid = 1'b1;
            end
            if (n == 202) begin upd_valid = 1'b0; upd_mispredict = 1'b0; end
        end while (init_busy && n < 2000);
        upd_valid = 1'b0; upd_mispredict = 1'b0;
        checks++; if (n !== 256) begin errors++; $display("FAIL restart_cycles: got %0d expected 256", n); end
        set_pc(16'h0012);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b0, 1'b0, 16'h0013}) begin errors++; $display("FAIL init_cleared: got %b %b %h expected 0 0 0013", pred_hit, pred_taken, pred_next_pc); end
        checks++; if (mispredict_cnt !== 16'h0) begin errors++; $display("FAIL init_drop_cnt: got %h expected 0000", mispredict_cnt); end
    endtask

    task automatic test_mispredict_sat();
        upd(16'h0A0A, 1, 0, 16'h0000, 1);
        upd(16'h0A0A, 1, 0, 16'h0000, 0);
        upd(16'h0A0A, 1, 0, 16'h0000, 1);
        checks++; if (mispredict_cnt !== 16'd2) begin errors++; $display("FAIL mis_count: got %h expected 0002", mispredict_cnt); end
        @(negedge clk);
        upd_pc = 16'h0A0A; upd_is_cond = 1'b1; upd_taken = 1'b0; upd_target = 16'h0000;
        upd_mispredict = 1'b1; upd_valid = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        upd_valid = 1'b0; upd_mispredict = 1'b0;
        checks++; if (mispredict_cnt !== 16'hFFFF) begin errors++; $display("FAIL mis_sat: got %h expected ffff", mispredict_cnt); end
        upd(16'h0A0A, 1, 0, 16'h0000, 1);
        checks++; if (mispredict_cnt !== 16'hFFFF) begin errors++; $display("FAIL mis_hold: got %h expected ffff", mispredict_cnt); end
    endtask

`ifdef BP_GSHARE_EN
    task automatic test_gshare();
        set_pc(16'h0033);
        upd(16'h0033, 0, 1, 16'h0100, 0);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b1, 1'b1, 16'h0100}) begin errors++; $display("FAIL gs_ghr00: got %b %b %h expected 1 1 0100", pred_hit, pred_taken, pred_next_pc); end
        for (int i = 0; i < 8; i++) upd(16'h0500, 1, 1, 16'h0600, 0);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b0, 1'b0, 16'h0034}) begin errors++; $display("FAIL gs_ghrff_miss: got %b %b %h expected 0 0 0034", pred_hit, pred_taken, pred_next_pc); end
        upd(16'h0033, 0, 1, 16'h0200, 0);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b1, 1'b1, 16'h0200}) begin errors++; $display("FAIL gs_ghrff_hit: got %b %b %h expected 1 1 0200", pred_hit, pred_taken, pred_next_pc); end
        for (int i = 0; i < 8; i++) upd(16'h0500, 1, 0, 16'h0600, 0);
        checks++; if ({pred_hit, pred_taken, pred_next_pc} !== {1'b1, 1'b1, 16'h0100}) begin errors++; $display("FAIL gs_back00: got %b %b %h expected 1 1 0100", pred_hit, pred_taken, pred_next_pc); end
    endtask
`endif

    initial begin
        reset = 1'b1; pc = 16'h0; upd_valid = 1'b0; upd_pc = 16'h0; upd_is_cond = 1'b0;
        upd_taken = 1'b0; upd_target = 16'h0; upd_mispredict = 1'b0;
        test_reset();
`ifdef BP_GSHARE_EN
        test_gshare();
`else
        test_train();
        test_miss_and_jump();
        test_same_cycle();
        test_reset_mid_init();
        test_mispredict_sat();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
